fifo_32_8: RTL and testbench

Width-downsizing synchronous FIFO: accepts 32-bit words on the write port and delivers them one byte per read, least-significant byte first. It is the mirror of the team's 8-to-32 upsizing FIFO. It sits between a word-wide producer (bus/DMA side) and a byte-wide consumer (serializer/UART-style peripheral) in the same clock domain. Storage is a byte-addressed circular buffer with show-ahead read data.

---
 rtl/fifo_32_8_if.sv | 37 +++
 rtl/fifo_32_8.sv | 94 +++++++++
 tb/tb_fifo_32_8.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_32_8_if.sv
// fifo_32_8_if: handshake/data bundle for the 32-to-8 downsizing FIFO.
//   master : producer/consumer side (drives w_data, wr_en, rd_en)
//   slave  : FIFO side (drives full, r_data, empty, count, optional error flags)
// Optional feature macro: FIFO_32_8_ERR_FLAGS_EN adds overflow/underflow.
interface fifo_32_8_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int WRITE_WIDTH = 4 * DATA_WIDTH,
  parameter int DEPTH       = 16
);
  logic [WRITE_WIDTH-1:0]       w_data;
  logic                         wr_en;
  logic                         full;
  logic [DATA_WIDTH-1:0]        r_data;
  logic                         rd_en;
  logic                         empty;
  logic [$clog2(DEPTH+1)-1:0]   count;
`ifdef FIFO_32_8_ERR_FLAGS_EN
  logic                         overflow;
  logic                         underflow;
`endif

  modport master (
    output w_data, wr_en, rd_en,
    input  full, r_data, empty, count
`ifdef FIFO_32_8_ERR_FLAGS_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  w_data, wr_en, rd_en,
    output full, r_data, empty, count
`ifdef FIFO_32_8_ERR_FLAGS_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/fifo_32_8.sv
// fifo_32_8: width-downsizing synchronous FIFO. Accepts 32-bit words and
// delivers them one byte per read, least-significant byte first, from a
// byte-addressed circular buffer with show-ahead read data.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (pointers/count cleared, memory kept)
//   bus  - fifo_32_8_if.slave: w_data/wr_en write port, r_data/rd_en read port,
//          full (fewer than 4 free bytes), empty, count (bytes stored)
// Optional feature macro: FIFO_32_8_ERR_FLAGS_EN adds sticky overflow and
// underflow flags on the interface.
module fifo_32_8 #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 2 ** ADDR_WIDTH,
  parameter int WRITE_WIDTH = 4 * DATA_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  fifo_32_8_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);

  if ((DEPTH % 4 != 0) || (DEPTH < 4)) begin : g_bad_depth
    $warning("fifo_32_8: DEPTH must be a multiple of 4 and at least 4");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full, empty;
  logic                  wr_fire, rd_fire;

  assign full    = (count_q > CW'(DEPTH - 4));
  assign empty   = (count_q == '0);
  assign wr_fire = bus.wr_en && !full;
  assign rd_fire = bus.rd_en && !empty;

  assign bus.full   = full;
  assign bus.empty  = empty;
  assign bus.count  = count_q;
  assign bus.r_data = mem_q[rd_ptr_q];

  // Explicit wrap compares keep modulo-DEPTH behaviour for non-power-of-2 depths.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (wr_fire ? CW'(4) : '0) - (rd_fire ? CW'(1) : '0);
    if (wr_fire) begin
      wr_ptr_d = (wr_ptr_q == ADDR_WIDTH'(DEPTH - 4)) ? '0 : wr_ptr_q + ADDR_WIDTH'(4);
    end
    if (rd_fire) begin
      rd_ptr_d = (rd_ptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // wr_ptr is always 4-aligned, so a word never straddles the wrap point.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) begin
      for (int unsigned k = 0; k < 4; k++) begin
        mem_q[wr_ptr_q + ADDR_WIDTH'(k)] <= bus.w_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef FIFO_32_8_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en && full)  overflow_q  <= 1'b1;
      if (bus.rd_en && empty) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo_32_8.sv
// tb_fifo_32_8: directed self-checking bench for fifo_32_8 (DEPTH=16).
module tb_fifo_32_8;
  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_fail;

  fifo_32_8_if #(.DATA_WIDTH(8), .WRITE_WIDTH(32), .DEPTH(16)) bus ();

  fifo_32_8 #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(16), .WRITE_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] w);
    bus.w_data = w;
    bus.wr_en  = 1'b1;
    tick();
    bus.wr_en  = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] exp);
    check({tag, "_nonempty"}, 32'(bus.empty), 32'd0);
    check(tag, 32'(bus.r_data), 32'(exp));
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.w_data  = '0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full",  32'(bus.full),  32'd0);
    check("rst_count", 32'(bus.count), 32'd0);

    // Read on empty is ignored
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("uf_count", 32'(bus.count), 32'd0);
    check("uf_empty", 32'(bus.empty), 32'd1);
`ifdef FIFO_32_8_ERR_FLAGS_EN
    check("uf_flag", 32'(bus.underflow), 32'd1);
    tick();
    check("uf_sticky", 32'(bus.underflow), 32'd1);
    check("uf_no_of", 32'(bus.overflow), 32'd0);
`endif

    // Single word, byte order; rd_ptr must still be 0 after ignored read
    do_write(32'h4433_2211);
    check("w1_count", 32'(bus.count), 32'd4);
    check("w1_empty", 32'(bus.empty), 32'd0);
    read_check("w1_b0", 8'h11);
    read_check("w1_b1", 8'h22);
    read_check("w1_b2", 8'h33);
    check("w1_count3", 32'(bus.count), 32'd1);
    read_check("w1_b3", 8'h44);
    check("w1_drained", 32'(bus.empty), 32'd1);
    check("w1_count0", 32'(bus.count), 32'd0);

    // Fill, drop at full, partial read, wrap-around write
    do_reset();
`ifdef FIFO_32_8_ERR_FLAGS_EN
    check("rst_uf_clr", 32'(bus.underflow), 32'd0);
`endif
    do_write(32'h0302_0100);
    do_write(32'h0706_0504);
    do_write(32'h0B0A_0908);
    check("fill12_full", 32'(bus.full), 32'd0);
    do_write(32'h0F0E_0D0C);
    check("fill_full",  32'(bus.full),  32'd1);
    check("fill_count", 32'(bus.count), 32'd16);
    do_write(32'hDEAD_BEEF);
    check("drop_count", 32'(bus.count), 32'd16);
`ifdef FIFO_32_8_ERR_FLAGS_EN
    check("of_flag", 32'(bus.overflow), 32'd1);
    tick();
    check("of_sticky", 32'(bus.overflow), 32'd1);
`endif
    for (int i = 0; i < 6; i++) read_check("fill_rd", 8'(i));
    check("rd6_count", 32'(bus.count), 32'd10);
    check("rd6_full",  32'(bus.full),  32'd0);
    do_write(32'h1312_1110);
    check("wrap_count", 32'(bus.count), 32'd14);
    check("wrap_full",  32'(bus.full),  32'd1);
    for (int i = 6; i < 20; i++) read_check("wrap_rd", 8'(i));
    check("wrap_empty", 32'(bus.empty), 32'd1);

    // Simultaneous write and read at count=5
    do_reset();
    do_write(32'h0302_0100);
    do_write(32'h0706_0504);
    for (int i = 0; i < 3; i++) read_check("sim_pre", 8'(i));
    check("sim_count5", 32'(bus.count), 32'd5);
    check("sim_head3", 32'(bus.r_data), 32'h03);
    bus.w_data = 32'h0B0A_0908;
    bus.wr_en  = 1'b1;
    bus.rd_en  = 1'b1;
    tick();
    bus.wr_en  = 1'b0;
    bus.rd_en  = 1'b0;
    check("sim_count8", 32'(bus.count), 32'd8);
    for (int i = 4; i < 12; i++) read_check("sim_rd", 8'(i));
    check("sim_empty", 32'(bus.empty), 32'd1);

    // Reset mid-stream at count=9, with requests in the reset cycle
    do_reset();
    do_write(32'h0302_0100);
    do_write(32'h0706_0504);
    do_write(32'h0B0A_0908);
    for (int i = 0; i < 3; i++) read_check("mid_pre", 8'(i));
    check("mid_count9", 32'(bus.count), 32'd9);
    rst        = 1'b1;
    bus.w_data = 32'h1111_1111;
    bus.wr_en  = 1'b1;
    bus.rd_en  = 1'b1;
    tick();
    rst        = 1'b0;
    bus.wr_en  = 1'b0;
    bus.rd_en  = 1'b0;
    check("mid_count0", 32'(bus.count), 32'd0);
    check("mid_empty",  32'(bus.empty), 32'd1);
    do_write(32'hAABB_CCDD);
    check("mid_count4", 32'(bus.count), 32'd4);
    read_check("mid_b0", 8'hDD);
    read_check("mid_b1", 8'hCC);
    read_check("mid_b2", 8'hBB);
    read_check("mid_b3", 8'hAA);

    // Steady state: one write per 4 cycles with continuous reads
    do_reset();
    do_write(32'h0302_0100);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 4; c++) begin
        check("ss_head", 32'(bus.r_data), 32'(8'(4 * p + c)));
        bus.w_data = {8'(4*p+7), 8'(4*p+6), 8'(4*p+5), 8'(4*p+4)};
        bus.wr_en  = (c == 0);
        bus.rd_en  = 1'b1;
        tick();
      end
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      check("ss_count", 32'(bus.count), 32'd4);
      check("ss_full",  32'(bus.full),  32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
